// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the integer register file and its scoreboard:
//   XLEN_DEFAULT / NUM_REGS_DEFAULT : default data width and register count
//   addr_width()                    : address width for a given register count
//   rf_state_e                      : init-sweep FSM encoding
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEFAULT     = 64;
  localparam int NUM_REGS_DEFAULT = 32;

  // Address width for a register count. It never returns less than 1, so a
  // two-entry file still gets a usable address bit.
  function automatic int addr_width(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Busy bit per architectural register. A long-latency op that has been issued
// sets the busy bit of its destination. When its result is written back, that
// bit is cleared. If a set and a clear hit the same register in the same
// cycle, the set wins. Register 0 is never busy. All bits clear asynchronously
// on reset.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset, clears every busy bit
//   set_en    mark set_addr busy at the next edge
//   set_addr  register to mark busy
//   clr_en    mark clr_addr not busy at the next edge
//   clr_addr  register to release
//   busy      registered busy vector, bit 0 constant 0
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_addr] = 1'b1;
    if (clr_en) clr_vec[clr_addr] = 1'b1;
    // The clear is applied before the set, so the set wins on a same-address
    // collision.
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Integer register file for the RV64IM core. It contains a built-in
// scoreboard and a second write-back path for long-latency (MUL/DIV) results.
// The storage array has no reset, so it stays RAM-inferable. After reset, an
// init sweep clears one entry per clock. Read ports are combinational, and
// same-cycle write forwarding is optional.
//
// FSM states:
//   state | meaning
//   INIT  | sweep writes 0 to entry[cnt_q] each edge; ports ignored, READY=0
//   RUN   | normal operation until the next reset
//
// Ports:
//   CLK, RESET        clock (rising edge), asynchronous active-high reset
//   READY             init sweep finished, file usable
//   R_ADDR/R_DATA     NUM_READ packed read ports (address / data)
//   R_BUSY            scoreboard bit of each addressed register
//   WR_EN/ADDR/DATA   primary (ALU) write port, has priority
//   RSV_EN/RSV_ADDR   reserve destination of an issued long-latency op
//   LL_VALID/ADDR/DATA long-latency write-back request
//   LL_READY          long-latency result accepted this cycle
//   SB_BUSY           full scoreboard vector
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  parameter  int NUM_READ = 2,
  parameter  int BYPASS   = 1,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  output logic                     READY,
  input  logic [NUM_READ*AW-1:0]   R_ADDR,
  output logic [NUM_READ*XLEN-1:0] R_DATA,
  output logic [NUM_READ-1:0]      R_BUSY,
  input  logic                     WR_EN,
  input  logic [AW-1:0]            WR_ADDR,
  input  logic [XLEN-1:0]          WR_DATA,
  input  logic                     RSV_EN,
  input  logic [AW-1:0]            RSV_ADDR,
  input  logic                     LL_VALID,
  input  logic [AW-1:0]            LL_ADDR,
  input  logic [XLEN-1:0]          LL_DATA,
  output logic                     LL_READY,
  output logic [NUM_REGS-1:0]      SB_BUSY
);

  rf_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready;

  logic [XLEN-1:0] mem [NUM_REGS];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic                ll_xfer;
  logic                wr_fwd;
  logic [NUM_REGS-1:0] sb_busy;

  // ---------------------------------------------------------------------------
  // Init sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NUM_REGS - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign ready = (state_q == RUN);
  assign READY = ready;

  // ---------------------------------------------------------------------------
  // Write arbitration: sweep, then primary, then long-latency
  // ---------------------------------------------------------------------------
  // The LL port stalls whenever the primary port wants the single array write.
  assign LL_READY = ready & ~WR_EN;
  assign ll_xfer  = LL_VALID & LL_READY;
  assign wr_fwd   = ready & WR_EN;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!ready) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
    end else if (WR_EN) begin
      mem_we    = (WR_ADDR != '0);
      mem_waddr = WR_ADDR;
      mem_wdata = WR_DATA;
    end else if (ll_xfer) begin
      // A transfer to x0 still completes the handshake; only the write is dropped.
      mem_we    = (LL_ADDR != '0);
      mem_waddr = LL_ADDR;
      mem_wdata = LL_DATA;
    end
  end

  // No reset on the array, so it can map to RAM. The sweep handles clearing.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (CLK),
    .rst      (RESET),
    .set_en   (ready & RSV_EN),
    .set_addr (RSV_ADDR),
    .clr_en   (ll_xfer),
    .clr_addr (LL_ADDR),
    .busy     (sb_busy)
  );

  assign SB_BUSY = sb_busy;

  // ---------------------------------------------------------------------------
  // Read ports with optional same-cycle forwarding
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = R_ADDR[gi*AW +: AW];

    always_comb begin
      data = mem[addr];
      busy = sb_busy[addr];
      if (BYPASS != 0) begin
        if (wr_fwd && (WR_ADDR == addr)) begin
          data = WR_DATA;
        end else if (ll_xfer && (LL_ADDR == addr)) begin
          // The result that is landing now also releases the register.
          data = LL_DATA;
          busy = 1'b0;
        end
      end
      // During the sweep the array still holds stale data, so reads are masked.
      if (!ready || (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign R_DATA[gi*XLEN +: XLEN] = data;
    assign R_BUSY[gi]              = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int NR  = 32;
  localparam int AWT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        ll_valid;
  logic [4:0]  ll_addr;
  logic [63:0] ll_data;
  logic [9:0]  r_addr;

  logic         ready_b, ready_n;
  logic [127:0] r_data_b, r_data_n;
  logic [1:0]   r_busy_b, r_busy_n;
  logic         ll_ready_b, ll_ready_n;
  logic [31:0]  sb_busy_b, sb_busy_n;

  regfile_sb #(.XLEN(64), .NUM_REGS(NR), .NUM_READ(2), .BYPASS(1)) dut (
    .CLK(clk), .RESET(rst), .READY(ready_b), .R_ADDR(r_addr), .R_DATA(r_data_b),
    .R_BUSY(r_busy_b), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .LL_VALID(ll_valid), .LL_ADDR(ll_addr),
    .LL_DATA(ll_data), .LL_READY(ll_ready_b), .SB_BUSY(sb_busy_b)
  );

  regfile_sb #(.XLEN(64), .NUM_REGS(NR), .NUM_READ(2), .BYPASS(0)) dut_nb (
    .CLK(clk), .RESET(rst), .READY(ready_n), .R_ADDR(r_addr), .R_DATA(r_data_n),
    .R_BUSY(r_busy_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .LL_VALID(ll_valid), .LL_ADDR(ll_addr),
    .LL_DATA(ll_data), .LL_READY(ll_ready_n), .SB_BUSY(sb_busy_n)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model (architectural view) ----------------
  logic [63:0] m_mem [NR];
  logic [31:0] m_busy;
  bit          m_ready;
  int          m_cnt;

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_busy  = '0;
  endtask

  task automatic model_edge();
    bit xfer;
    if (!m_ready) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NR) m_ready = 1'b1;
    end else begin
      xfer = ll_valid && !wr_en;
      if (wr_en) begin
        if (wr_addr != 0) m_mem[wr_addr] = wr_data;
      end else if (xfer && ll_addr != 0) begin
        m_mem[ll_addr] = ll_data;
      end
      if (xfer) m_busy[ll_addr] = 1'b0;
      if (rsv_en) m_busy[rsv_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic exp_read(input bit byp, input logic [4:0] a,
                          output logic [63:0] d, output logic bz);
    d  = m_mem[a];
    bz = m_busy[a];
    if (byp && wr_en && wr_addr == a) begin
      d = wr_data;
    end else if (byp && ll_valid && !wr_en && ll_addr == a) begin
      d  = ll_data;
      bz = 1'b0;
    end
    if (!m_ready || a == 0) begin
      d  = '0;
      bz = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] d;
    logic        bz;
    logic [4:0]  a;
    bit          exp_llr;
    exp_llr = m_ready && !wr_en;
    chk({tag, " ready"},       64'(ready_b),    64'(m_ready));
    chk({tag, " ready_nb"},    64'(ready_n),    64'(m_ready));
    chk({tag, " ll_ready"},    64'(ll_ready_b), 64'(exp_llr));
    chk({tag, " ll_ready_nb"}, 64'(ll_ready_n), 64'(exp_llr));
    chk({tag, " sb_busy"},     64'(sb_busy_b),  64'(m_busy));
    chk({tag, " sb_busy_nb"},  64'(sb_busy_n),  64'(m_busy));
    for (int p = 0; p < 2; p++) begin
      a = r_addr[p*AWT +: AWT];
      exp_read(1'b1, a, d, bz);
      chk($sformatf("%s rdata%0d", tag, p), r_data_b[p*64 +: 64], d);
      chk($sformatf("%s rbusy%0d", tag, p), 64'(r_busy_b[p]), 64'(bz));
      exp_read(1'b0, a, d, bz);
      chk($sformatf("%s rdata%0d_nb", tag, p), r_data_n[p*64 +: 64], d);
      chk($sformatf("%s rbusy%0d_nb", tag, p), 64'(r_busy_n[p]), 64'(bz));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0;
    ll_valid = 0; ll_addr = 0; ll_data = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr_en;  logic [4:0] wa;   logic [63:0] wd;
    logic        rsv;    logic [4:0] rsva;
    logic        llv;    logic [4:0] lla;  logic [63:0] lld;
    logic [4:0]  ra0;    logic [4:0] ra1;
    logic        e_llr;  logic [31:0] e_sb;
    logic [63:0] e_d0;   logic [63:0] e_d0n;
    logic        e_b0;   logic e_b0n;
    logic [63:0] e_d1;   logic [63:0] e_d1n;
    logic        e_b1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 5, 64'h1234, 0, 0, 0, 0, 0,          5, 0, 0, 32'h0,   64'h1234, 64'h0,    0, 0, 64'h0,  64'h0,  0};
    tbl[1]  = '{0, 0, 64'h0,    0, 0, 0, 0, 0,          5, 5, 1, 32'h0,   64'h1234, 64'h1234, 0, 0, 64'h1234, 64'h1234, 0};
    tbl[2]  = '{1, 0, '1,       0, 0, 0, 0, 0,          5, 0, 0, 32'h0,   64'h1234, 64'h1234, 0, 0, 64'h0,  64'h0,  0};
    tbl[3]  = '{0, 0, 64'h0,    1, 0, 0, 0, 0,          5, 0, 1, 32'h0,   64'h1234, 64'h1234, 0, 0, 64'h0,  64'h0,  0};
    tbl[4]  = '{0, 0, 64'h0,    1, 7, 0, 0, 0,          7, 0, 1, 32'h0,   64'h0,    64'h0,    0, 0, 64'h0,  64'h0,  0};
    tbl[5]  = '{0, 0, 64'h0,    0, 0, 0, 0, 0,          7, 0, 1, 32'h80,  64'h0,    64'h0,    1, 1, 64'h0,  64'h0,  0};
    tbl[6]  = '{1, 6, 64'h66,   0, 0, 1, 7, 64'hDEAD,   7, 6, 0, 32'h80,  64'h0,    64'h0,    1, 1, 64'h66, 64'h0,  0};
    tbl[7]  = '{0, 0, 64'h0,    0, 0, 1, 7, 64'hDEAD,   7, 6, 1, 32'h80,  64'hDEAD, 64'h0,    0, 1, 64'h66, 64'h66, 0};
    tbl[8]  = '{0, 0, 64'h0,    0, 0, 0, 0, 0,          7, 6, 1, 32'h0,   64'hDEAD, 64'hDEAD, 0, 0, 64'h66, 64'h66, 0};
    tbl[9]  = '{0, 0, 64'h0,    1, 9, 0, 0, 0,          9, 0, 1, 32'h0,   64'h0,    64'h0,    0, 0, 64'h0,  64'h0,  0};
    tbl[10] = '{0, 0, 64'h0,    1, 9, 1, 9, 64'hBEEF,   9, 0, 1, 32'h200, 64'hBEEF, 64'h0,    0, 1, 64'h0,  64'h0,  0};
    tbl[11] = '{0, 0, 64'h0,    0, 0, 0, 0, 0,          9, 0, 1, 32'h200, 64'hBEEF, 64'hBEEF, 1, 1, 64'h0,  64'h0,  0};

    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    idle_inputs();
    r_addr = '0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("por ready", 64'(ready_b), 64'h0);
    chk("por sb_busy", 64'(sb_busy_b), 64'h0);
    tick(); tick();
    rst = 1'b0;

    // Initial sweep with LL traffic offered; it must be ignored.
    ll_valid = 1; ll_addr = 4; ll_data = 64'hAA;
    rsv_en = 1; rsv_addr = 4;
    for (int k = 0; k < NR; k++) begin
      r_addr = {5'd4, 5'(k)};
      #3;
      chk($sformatf("sweep%0d ready", k), 64'(ready_b), 64'h0);
      check_all("sweep");
      tick();
    end
    idle_inputs();
    #3;
    chk("post-sweep ready", 64'(ready_b), 64'h1);
    chk("post-sweep sb", 64'(sb_busy_b), 64'h0);
    tick();

    // Table-driven directed vectors
    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rsv_en = tbl[i].rsv; rsv_addr = tbl[i].rsva;
      ll_valid = tbl[i].llv; ll_addr = tbl[i].lla; ll_data = tbl[i].lld;
      r_addr = {tbl[i].ra1, tbl[i].ra0};
      #3;
      chk($sformatf("t%0d ll_ready", i),    64'(ll_ready_b), 64'(tbl[i].e_llr));
      chk($sformatf("t%0d ll_ready_nb", i), 64'(ll_ready_n), 64'(tbl[i].e_llr));
      chk($sformatf("t%0d sb", i),          64'(sb_busy_b),  64'(tbl[i].e_sb));
      chk($sformatf("t%0d sb_nb", i),       64'(sb_busy_n),  64'(tbl[i].e_sb));
      chk($sformatf("t%0d d0", i),    r_data_b[63:0],    tbl[i].e_d0);
      chk($sformatf("t%0d d0_nb", i), r_data_n[63:0],    tbl[i].e_d0n);
      chk($sformatf("t%0d b0", i),    64'(r_busy_b[0]),  64'(tbl[i].e_b0));
      chk($sformatf("t%0d b0_nb", i), 64'(r_busy_n[0]),  64'(tbl[i].e_b0n));
      chk($sformatf("t%0d d1", i),    r_data_b[127:64],  tbl[i].e_d1);
      chk($sformatf("t%0d d1_nb", i), r_data_n[127:64],  tbl[i].e_d1n);
      chk($sformatf("t%0d b1", i),    64'(r_busy_b[1]),  64'(tbl[i].e_b1));
      chk($sformatf("t%0d b1_nb", i), 64'(r_busy_n[1]),  64'(tbl[i].e_b1));
      tick();
    end

    // Mid-run reset with busy registers and an in-flight LL result
    idle_inputs();
    wr_en = 1; wr_addr = 5; wr_data = 64'h55;
    rsv_en = 1; rsv_addr = 3;
    #3; check_all("pre-rst a"); tick();
    idle_inputs();
    rsv_en = 1; rsv_addr = 12;
    #3; check_all("pre-rst b"); tick();
    idle_inputs();
    ll_valid = 1; ll_addr = 3; ll_data = 64'hCAFE;
    r_addr = {5'd12, 5'd3};
    #2;
    chk("pre-rst sb", 64'(sb_busy_b), 64'h1208);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst ready",       64'(ready_b),    64'h0);
    chk("rst ll_ready",    64'(ll_ready_b), 64'h0);
    chk("rst sb_busy",     64'(sb_busy_b),  64'h0);
    chk("rst ready_nb",    64'(ready_n),    64'h0);
    chk("rst ll_ready_nb", 64'(ll_ready_n), 64'h0);
    chk("rst sb_busy_nb",  64'(sb_busy_n),  64'h0);
    chk("rst rdata",       r_data_b,        128'h0);
    chk("rst rbusy",       64'(r_busy_b),   64'h0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < NR; k++) begin
      #3;
      chk($sformatf("resweep%0d ready", k), 64'(ready_b), 64'h0);
      chk($sformatf("resweep%0d ll_ready", k), 64'(ll_ready_b), 64'h0);
      check_all("resweep");
      tick();
    end
    ll_valid = 0;
    #3;
    chk("resweep done ready", 64'(ready_b), 64'h1);
    tick();
    for (int r = 0; r < NR; r += 2) begin
      r_addr = {5'(r + 1), 5'(r)};
      #3;
      chk($sformatf("zero x%0d", r),        r_data_b[63:0],   64'h0);
      chk($sformatf("zero x%0d", r + 1),    r_data_b[127:64], 64'h0);
      chk($sformatf("zero_nb x%0d", r),     r_data_n[63:0],   64'h0);
      chk($sformatf("zero_nb x%0d", r + 1), r_data_n[127:64], 64'h0);
      tick();
    end

    // Randomized traffic against the model
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      bit hold;
      hold = ll_valid && !(m_ready && !wr_en);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 5'($urandom_range(0, 15));
      wr_data  = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 15));
      if (!hold) begin
        ll_valid = ($urandom_range(0, 1) == 1);
        ll_addr  = 5'($urandom_range(0, 15));
        ll_data  = {$urandom, $urandom};
      end
      r_addr = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      #3;
      check_all($sformatf("rnd%0d", c));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the RV64IM core with a built-in scoreboard and a second write-back path for long-latency results (MUL/DIV).
- Storage is a clocked array that is never reset directly, so it stays RAM-inferable. After reset, an init sweep zeroes it one entry per cycle.
- Read ports are combinational, with optional same-cycle write forwarding.
- Sits between decode/hazard logic and the execute/write-back stages.

Parameters:
XLEN, 64, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_READ, 2, number of read ports
BYPASS, 1, 1 = forward same-cycle write data and busy-clear onto read ports
AW, $clog2(NUM_REGS), address width (localparam, not overridable)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
READY  output  1  init sweep complete; file usable
R_ADDR  input  NUM_READ*AW  read addresses, port i at [i*AW +: AW]
R_DATA  output  NUM_READ*XLEN  read data, port i at [i*XLEN +: XLEN]
R_BUSY  output  NUM_READ  scoreboard bit of each addressed register
WR_EN  input  1  primary (ALU) write enable
WR_ADDR  input  AW  primary write address
WR_DATA  input  XLEN  primary write data
RSV_EN  input  1  reserve destination of an issued long-latency op
RSV_ADDR  input  AW  register to mark busy
LL_VALID  input  1  long-latency result valid
LL_ADDR  input  AW  long-latency destination
LL_DATA  input  XLEN  long-latency result
LL_READY  output  1  long-latency result accepted this cycle
SB_BUSY  output  NUM_REGS  full scoreboard vector

Behaviour:
- Reset behaviour (asynchronous, immediate on RESET high):
  - State goes to INIT and the sweep counter goes to 0.
  - READY=0, LL_READY=0, SB_BUSY=0. R_DATA is forced to 0 and R_BUSY=0.
  - An in-flight LL result is dropped; the producer must reissue it.
- FSM states are INIT and RUN.
  - INIT: each rising edge after RESET deasserts writes 0 to entry[counter] and increments the counter.
  - The edge that writes entry NUM_REGS-1 moves the FSM to RUN.
  - READY=1 from that edge onward, i.e. READY is low for exactly NUM_REGS cycles after deassertion.
  - In INIT, all WR, RSV and LL inputs are ignored, LL_READY=0 and R_DATA=0.
  - RUN persists until RESET.
- Reads are combinational.
  - Address 0 always returns 0 with busy=0.
  - BYPASS=1: if a write commits this cycle to a matching nonzero address, R_DATA returns that write's data. If that write is an LL transfer, R_BUSY=0 for that read.
  - BYPASS=0: reads return array contents and registered busy only.
- Write ports: at most one array write per cycle; the primary port has priority.
  - LL_READY = READY & ~WR_EN.
  - An LL transfer occurs when LL_VALID & LL_READY, and writes at the clock edge.
  - While LL_VALID is high and LL_READY is low, the producer holds LL_ADDR and LL_DATA stable.
  - Writes to address 0 are discarded; a transfer to address 0 still completes the handshake.
- Scoreboard:
  - RSV_EN with RSV_ADDR != 0 sets busy[RSV_ADDR] at the edge. Reserving an already-busy register keeps it busy; no error is flagged.
  - An LL transfer clears busy[LL_ADDR].
  - Simultaneous reserve and release on the same address: set wins, busy stays 1, data is written.
  - An LL transfer to a non-busy register still writes.
  - A primary write to a busy register writes and leaves busy unchanged (WAW is the hazard unit's concern).
  - SB_BUSY[0] is constant 0.
- Latency:
  - Writes are visible in the array the cycle after the edge, and in the same cycle when BYPASS=1.
  - Busy changes are visible the cycle after the edge, except an LL clear, which is forwarded when BYPASS=1.

Decomposition:
- Shared package regfile_pkg holds:
  - the XLEN and NUM_REGS defaults
  - the AW helper function
  - the FSM enum {INIT, RUN}
- One sub-module, regfile_scoreboard: the busy vector with set/clear ports, set-wins priority and async clear.
- Storage, init FSM, write arbitration and read/bypass muxes stay in regfile_sb.

Test Plan:
- Write 0x55 to x5, pulse RESET, release -> READY=0 for exactly 32 cycles then 1; reading x5 returns 0; LL_READY=0 throughout INIT.
- RUN, WR_EN x5=0x1234 while port0 reads x5 -> same-cycle R_DATA0=0x1234 with BYPASS=1 (old value with BYPASS=0); next cycle 0x1234 in both builds.
- WR_EN x0=0xFFFF_FFFF_FFFF_FFFF, port1 reads x0 -> R_DATA1=0, R_BUSY[1]=0; RSV x0 -> SB_BUSY=0.
- RSV x7 -> next cycle SB_BUSY[7]=1 and R_BUSY for x7 =1. Then LL_VALID x7=0xDEAD with WR_EN=1 -> LL_READY=0 and the transfer is held. Next cycle WR_EN=0 -> transfer occurs, busy[7]=0 afterwards, x7 reads 0xDEAD.
- busy[9]=1, same cycle RSV x9 plus LL transfer x9=0xBEEF -> after the edge busy[9]=1 and x9 reads 0xBEEF.
- Mid-run with busy[3]=1, busy[12]=1 and LL_VALID high, assert RESET between edges -> READY, LL_READY and SB_BUSY go 0 immediately. After release, the 32-cycle sweep repeats and every register reads 0.
